// File: rtl/serial_sub4bit_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings, default width
// and the bit-counter sizing helper.
package serial_sub4bit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One spare bit so the counter can hold WIDTH itself without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_sub4bit_full_sub1bit.sv
// One-bit full subtractor: di = ai - bi - br, bo = borrow out.
// Purely combinational, no latency, no flow control.
module full_sub1bit (
    input  logic ai,
    input  logic bi,
    input  logic br,
    output logic di,
    output logic bo
);

    assign di = ai ^ bi ^ br;
    assign bo = (~ai & bi) | (~(ai ^ bi) & br);

endmodule

// File: rtl/serial_sub4bit.sv
// Bit-serial subtractor d = a - b - bin, LSB first, one bit per clock.
// Latency WIDTH cycles busy then a one-cycle done; start is ignored while busy.
module serial_sub4bit
    import serial_sub4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             overflow
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic             br_q,     br_d;
    logic [WIDTH-2:0] res_q,    res_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic [WIDTH-1:0] d_q,      d_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;

    logic di;
    logic bo;
    logic last_bit;
    logic accept;

    full_sub1bit u_cell (
        .ai (a_sh_q[0]),
        .bi (b_sh_q[0]),
        .br (br_q),
        .di (di),
        .bo (bo)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // DONE is not busy, so a start held there is taken back-to-back.
    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        br_d    = br_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = bo;
                // The low WIDTH-1 result bits live in res_q; the MSB is the
                // bit computed on the final edge and goes straight into d.
                res_d  = (WIDTH - 1)'({di, res_q} >> 1);
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    d_d     = {di, res_q};
                    bout_d  = bo;
                    ovf_d   = (a_msb_q != b_msb_q) && (di != a_msb_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b;
            br_d    = bin;
            res_d   = '0;
            cnt_d   = '0;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            br_q    <= br_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign d        = d_q;
    assign bout     = bout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_sub4bit.sv
// Scoreboard bench for serial_sub4bit: directed vectors plus a full 512-case sweep.
module tb_serial_sub4bit;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         overflow;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    serial_sub4bit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .d        (d),
        .bout     (bout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        exp_t        e;
        logic [W:0]  diff;
        diff   = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, ibin};
        e.d    = diff[W-1:0];
        e.bout = diff[W];
        e.ovf  = (ia[W-1] != ib[W-1]) && (e.d[W-1] != ia[W-1]);
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse and checks pulse/busy shape.
    bit prev_busy = 1'b0;
    bit prev_done = 1'b0;
    bit abort     = 1'b0;
    int run_len   = 0;

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 with d=%0h, expected no result at %0t", d, $time);
            end else begin
                e = exp_q.pop_front();
                check("result_d", {28'd0, d}, {28'd0, e.d});
                check("result_bout", {31'd0, bout}, {31'd0, e.bout});
                check("result_ovf", {31'd0, overflow}, {31'd0, e.ovf});
            end
            if (prev_done) check("done_width", 32'd2, 32'd1);
        end
        if (prev_busy && busy === 1'b0) begin
            if (abort) begin
                abort = 1'b0;
            end else begin
                check("busy_len", run_len, W);
                check("done_after_busy", {31'd0, done}, 32'd1);
            end
        end
        if (busy === 1'b1) run_len = prev_busy ? run_len + 1 : 1;
        if (rst === 1'b1 && busy === 1'b1) abort = 1'b1;
        prev_busy = (busy === 1'b1);
        prev_done = (done === 1'b1);
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            if (busy === 1'b0 && done === 1'b0) break;
            @(posedge clk); #1;
        end
        if (i == 40) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 40; i++) begin
            if (done === 1'b1) break;
            @(posedge clk); #1;
        end
        if (i == 40) check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         input logic [W-1:0] ed, input logic eb, input logic eo, input bit push);
        exp_t e;
        wait_idle();
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) begin
            e.d = ed; e.bout = eb; e.ovf = eo;
            exp_q.push_back(e);
        end
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         bin;
        logic [W-1:0] d;
        logic         bout, ovf;
    } vec_t;

    vec_t vecs[5] = '{
        '{4'b1001, 4'b1100, 1'b0, 4'b1101, 1'b1, 1'b0},
        '{4'b1100, 4'b1001, 1'b1, 4'b0010, 1'b0, 1'b0},
        '{4'b1000, 4'b1000, 1'b1, 4'b1111, 1'b1, 1'b0},
        '{4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1},
        '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1}
    };

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_d", {28'd0, d}, 32'd0);
            check("rst_bout_ovf", {30'd0, bout, overflow}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_busy_done", {30'd0, busy, done}, 32'd0);
            check("idle_d", {28'd0, d}, 32'd0);
        end
        @(posedge clk); #1;

        foreach (vecs[i])
            issue(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, vecs[i].ovf, 1'b1);

        // start pulsed in RUN cycle 2 must be ignored
        issue(4'b1001, 4'b1100, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        a = 4'b0000; b = 4'b0000; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        // back-to-back: start held in the DONE cycle
        issue(4'b1001, 4'b1100, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b1);
        wait_done();
        a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e.d = 4'b0010; e.bout = 1'b0; e.ovf = 1'b0;
        exp_q.push_back(e);
        check("b2b_no_idle", {31'd0, busy}, 32'd1);

        // reset in RUN cycle 2 aborts without a done pulse
        issue(4'b1001, 4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_d", {28'd0, d}, 32'd0);
        check("abort_bout_ovf", {30'd0, bout, overflow}, 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        issue(4'b1100, 4'b1001, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 512; k++) begin
            logic [W-1:0] ia, ib;
            logic         ibin;
            ia   = W'(k >> 5);
            ib   = W'(k >> 1);
            ibin = k[0];
            e    = model(ia, ib, ibin);
            issue(ia, ib, ibin, e.d, e.bout, e.ovf, 1'b1);
        end

        wait_idle();
        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
